// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types for the FFT frame sequencer: sample format, FSM states, default FFT size.
package fft_frame_ctrl_pkg;

  localparam int unsigned FFT_N    = 8;
  localparam int unsigned SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] r;
    logic signed [SAMPLE_W-1:0] i;
  } complex_product_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } fft_ctrl_state_e;

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry sample register file: one write port, two read ports returning entries k and k+N/2.
module fft_frame_buf
  import fft_frame_ctrl_pkg::*;
#(
  parameter int unsigned N = FFT_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   waddr,
  input  complex_product_t       wdata,
  input  logic [$clog2(N)-2:0]   raddr,
  output complex_product_t       rdata_0,
  output complex_product_t       rdata_1
);

  complex_product_t mem [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // N is a power of two, so k + N/2 is k with the index MSB set
  assign rdata_0 = mem[{1'b0, raddr}];
  assign rdata_1 = mem[{1'b1, raddr}];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the radix-2 FFT core: collects N samples, feeds butterfly pairs,
// waits for the core result and hands it downstream over valid/ready.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int unsigned N        = FFT_N,
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  complex_product_t         in_sample,
  output logic                     fft_enable,
  output complex_product_t         fft_data_0,
  output complex_product_t         fft_data_1,
  input  logic                     fft_out_valid,
  input  complex_product_t [N-1:0] fft_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output complex_product_t [N-1:0] res_data,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         frame_count
);

  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned K_W    = IDX_W - 1;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  fft_ctrl_state_e          state, state_d;
  logic [IDX_W-1:0]         idx, idx_d;
  logic [K_W-1:0]           k, k_d;
  logic [WAIT_W-1:0]        wait_cnt, wait_d;
  logic                     ov_prev;
  logic                     fft_enable_d;
  complex_product_t         data_0_d, data_1_d;
  logic                     res_valid_d;
  complex_product_t [N-1:0] res_data_d;
  logic                     timeout_d;
  logic [CNT_W-1:0]         count_d;
  logic                     buf_we;
  logic                     capture;
  complex_product_t         rd_0, rd_1;

  assign in_ready = (state == FILL);
  assign busy     = (state != FILL);

  fft_frame_buf #(.N(N)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we      (buf_we),
    .waddr   (idx),
    .wdata   (in_sample),
    .raddr   (k_d),
    .rdata_0 (rd_0),
    .rdata_1 (rd_1)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      k           <= '0;
      wait_cnt    <= '0;
      ov_prev     <= 1'b0;
      fft_enable  <= 1'b0;
      fft_data_0  <= '0;
      fft_data_1  <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      k           <= k_d;
      wait_cnt    <= wait_d;
      ov_prev     <= fft_out_valid;
      fft_enable  <= fft_enable_d;
      fft_data_0  <= data_0_d;
      fft_data_1  <= data_1_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      timeout_err <= timeout_d;
      frame_count <= count_d;
    end
  end

  // Next state; core drive is computed from the next state so it lines up with FEED/FLUSH
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    k_d          = k;
    wait_d       = wait_cnt;
    fft_enable_d = 1'b0;
    data_0_d     = '0;
    data_1_d     = '0;
    res_valid_d  = res_valid;
    res_data_d   = res_data;
    timeout_d    = 1'b0;
    count_d      = frame_count;
    buf_we       = 1'b0;
    capture      = fft_out_valid && !ov_prev;

    case (state)
      FILL: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (idx == IDX_W'(N - 1)) begin
            idx_d   = '0;
            k_d     = '0;
            state_d = FEED;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      FEED: begin
        if (k == K_W'(N / 2 - 1)) begin
          wait_d  = '0;
          state_d = FLUSH;
        end else begin
          k_d = k + K_W'(1);
        end
      end
      FLUSH: begin
        wait_d = wait_cnt + WAIT_W'(1);
        if (capture) begin
          res_valid_d = 1'b1;
          res_data_d  = fft_result;
          state_d     = OUT;
        end else if (wait_d == WAIT_W'(MAX_WAIT)) begin
          timeout_d = 1'b1;
          idx_d     = '0;
          state_d   = FILL;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          count_d     = frame_count + CNT_W'(1);
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (state_d == FEED) begin
      fft_enable_d = 1'b1;
      data_0_d     = rd_0;
      data_1_d     = rd_1;
    end else if (state_d == FLUSH) begin
      fft_enable_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural FFT core stub.
module tb_fft_frame_ctrl;
  import fft_frame_ctrl_pkg::*;

  localparam int N        = 8;
  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = 16;

  typedef complex_product_t [N-1:0] bins_t;

  typedef struct {
    logic in_valid;
    int   in_r;
    logic out_valid;
    int   res_base;
    logic res_ready;
    logic x_in_ready;
    logic x_en;
    int   x_d0;
    int   x_d1;
    logic x_res_valid;
    int   x_res_base;
    int   x_count;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  complex_product_t in_sample;
  logic             fft_enable;
  complex_product_t fft_data_0;
  complex_product_t fft_data_1;
  logic             fft_out_valid;
  bins_t            fft_result;
  logic             res_valid;
  logic             res_ready;
  bins_t            res_data;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] frame_count;

  int   res_base;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  fft_frame_ctrl #(.N(N), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sample     (in_sample),
    .fft_enable    (fft_enable),
    .fft_data_0    (fft_data_0),
    .fft_data_1    (fft_data_1),
    .fft_out_valid (fft_out_valid),
    .fft_result    (fft_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Core stub: bin b carries r = res_base + b, i = b
  always_comb begin
    for (int b = 0; b < N; b++) begin
      fft_result[b].r = SAMPLE_W'(res_base + b);
      fft_result[b].i = SAMPLE_W'(b);
    end
  end

  function automatic bins_t exp_bins(input int base);
    bins_t e;
    e = '0;
    if (base >= 0) begin
      for (int b = 0; b < N; b++) begin
        e[b].r = SAMPLE_W'(base + b);
        e[b].i = SAMPLE_W'(b);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bins(input string name, input bins_t act, input bins_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_frame(input int base);
    for (int i = 0; i < N; i++) begin
      in_valid    = 1'b1;
      in_sample.r = SAMPLE_W'(base + i);
      in_sample.i = '0;
      step();
    end
    in_valid = 1'b0;
  endtask

  function automatic void add(input logic iv, input int ir, input logic ov, input int rb,
                              input logic rr, input logic xir, input logic xen, input int xd0,
                              input int xd1, input logic xrv, input int xrb, input int xc);
    vec_t v;
    v.in_valid = iv;  v.in_r = ir;       v.out_valid = ov;  v.res_base = rb;
    v.res_ready = rr; v.x_in_ready = xir; v.x_en = xen;     v.x_d0 = xd0;
    v.x_d1 = xd1;     v.x_res_valid = xrv; v.x_res_base = xrb; v.x_count = xc;
    tbl.push_back(v);
  endfunction

  initial begin
    int pulses;
    int at;

    // Frame A: ramp 1..8, capture 6 cycles into FLUSH, hold result 3 cycles
    for (int i = 0; i < 8; i++) add(1, i + 1, 0, 0, 0, 1, 0, 0, 0, 0, -1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 1, k + 1, k + 5, 0, -1, 0);
    for (int j = 0; j < 6; j++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, 0);
    add(0, 0, 1, 10, 0, 0, 1, 0, 0, 0, -1, 0);
    for (int h = 0; h < 3; h++) add(0, 0, 1, 50, 0, 0, 0, 0, 0, 1, 10, 0);
    add(0, 0, 1, 50, 1, 0, 0, 0, 0, 1, 10, 0);
    // Frame B: toggled in_valid with junk on idle cycles, stale out_valid level ignored
    for (int o = 0; o < 15; o++) begin
      if (o % 2 == 0) add(1, 21 + o / 2, 1, 50, 0, 1, 0, 0, 0, 0, 10, 1);
      else            add(0, 99, 1, 50, 0, 1, 0, 0, 0, 0, 10, 1);
    end
    for (int k = 0; k < 4; k++) add(0, 0, 1, 50, 0, 0, 1, 21 + k, 25 + k, 0, 10, 1);
    for (int j = 0; j < 10; j++) add(0, 0, 1, 50, 0, 0, 1, 0, 0, 0, 10, 1);
    add(0, 0, 0, 50, 0, 0, 1, 0, 0, 0, 10, 1);
    add(0, 0, 1, 30, 0, 0, 1, 0, 0, 0, 10, 1);
    add(0, 0, 0, 30, 1, 0, 0, 0, 0, 1, 30, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 30, 2);

    reset = 1'b0; in_valid = 1'b0; in_sample = '0;
    fft_out_valid = 1'b0; res_ready = 1'b0; res_base = 0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst fft_enable", int'(fft_enable), 0);
    chk("rst fft_data_0", int'(fft_data_0), 0);
    chk("rst res_valid", int'(res_valid), 0);
    chk_bins("rst res_data", res_data, '0);
    chk("rst timeout_err", int'(timeout_err), 0);
    chk("rst frame_count", int'(frame_count), 0);
    reset = 1'b0;

    for (int v = 0; v < tbl.size(); v++) begin
      in_valid      = tbl[v].in_valid;
      in_sample.r   = SAMPLE_W'(tbl[v].in_r);
      in_sample.i   = '0;
      fft_out_valid = tbl[v].out_valid;
      res_base      = tbl[v].res_base;
      res_ready     = tbl[v].res_ready;
      chk($sformatf("v%0d in_ready", v), int'(in_ready), int'(tbl[v].x_in_ready));
      chk($sformatf("v%0d busy", v), int'(busy), int'(!tbl[v].x_in_ready));
      chk($sformatf("v%0d fft_enable", v), int'(fft_enable), int'(tbl[v].x_en));
      chk($sformatf("v%0d fft_data_0", v), int'(fft_data_0.r), tbl[v].x_d0);
      chk($sformatf("v%0d fft_data_1", v), int'(fft_data_1.r), tbl[v].x_d1);
      chk($sformatf("v%0d res_valid", v), int'(res_valid), int'(tbl[v].x_res_valid));
      chk_bins($sformatf("v%0d res_data", v), res_data, exp_bins(tbl[v].x_res_base));
      chk($sformatf("v%0d timeout_err", v), int'(timeout_err), 0);
      chk($sformatf("v%0d frame_count", v), int'(frame_count), tbl[v].x_count);
      step();
    end
    in_valid = 1'b0; fft_out_valid = 1'b0; res_ready = 1'b0;

    // Timeout: core never answers
    fill_frame(100);
    repeat (4) step();
    pulses = 0;
    at = -1;
    for (int j = 0; j < 80; j++) begin
      if (timeout_err) begin
        pulses++;
        if (at < 0) begin
          at = j;
          chk("to in_ready", int'(in_ready), 1);
          chk("to frame_count", int'(frame_count), 2);
          chk("to res_valid", int'(res_valid), 0);
        end
      end
      step();
    end
    chk("to position", at, MAX_WAIT);
    chk("to pulses", pulses, 1);

    // Reset in the middle of FLUSH, then a clean frame
    fill_frame(40);
    repeat (4) step();
    repeat (3) step();
    chk("pre-rst fft_enable", int'(fft_enable), 1);
    reset = 1'b1;
    #1;
    chk("mid-rst fft_enable", int'(fft_enable), 0);
    chk("mid-rst in_ready", int'(in_ready), 1);
    chk("mid-rst frame_count", int'(frame_count), 0);
    chk_bins("mid-rst res_data", res_data, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post-rst in_ready", int'(in_ready), 1);
    fill_frame(60);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("r%0d fft_enable", k), int'(fft_enable), 1);
      chk($sformatf("r%0d fft_data_0", k), int'(fft_data_0.r), 60 + k);
      chk($sformatf("r%0d fft_data_1", k), int'(fft_data_1.r), 64 + k);
      step();
    end
    repeat (2) step();
    fft_out_valid = 1'b1;
    res_base = 70;
    step();
    fft_out_valid = 1'b0;
    chk("r res_valid", int'(res_valid), 1);
    chk_bins("r res_data", res_data, exp_bins(70));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("r res_valid done", int'(res_valid), 0);
    chk("r frame_count", int'(frame_count), 1);
    chk("r in_ready", int'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
